// File: rtl/main_rx_if.sv
// Byte-side handshake of the UART receiver: held byte, status flags and the consumer's level ack.
interface main_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 receive_done_out;
  logic                 frame_error_out;
  logic                 overrun_out;

  modport master (
    input  rx_ack,
    output rx_data_out, receive_done_out, frame_error_out, overrun_out
  );

  modport slave (
    output rx_ack,
    input  rx_data_out, receive_done_out, frame_error_out, overrun_out
  );
endinterface

// File: rtl/main_rx.sv
// UART 8N1 receiver with oversampled mid-bit majority voting, start-glitch rejection and a
// level-handshake output register (valid held until ack, overrun flagged when a byte is dropped).
module main_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      baud_clk,
  input  logic      reset,
  input  logic      rx_data_in,
  main_rx_if.master rx_if
);

  localparam int M      = OVERSAMPLE / 2;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_A    = TICK_W'(M - 1);
  localparam logic [TICK_W-1:0] TICK_B    = TICK_W'(M);
  localparam logic [TICK_W-1:0] TICK_DEC  = TICK_W'(M + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state_q, state_d;
  logic                 rx_sync_p0, rx_sync_p1, rx_prev_p2;
  logic                 rx_s;
  logic [TICK_W-1:0]    tick_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tick_run, decide, bit_val, shift_en, complete;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // stage: two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_data_in;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  assign rx_s = rx_sync_p1;

  // stage: frame FSM
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s && rx_prev_p2) state_d = START;
      START:   if (decide) state_d = bit_val ? IDLE : DATA;
      DATA:    if (decide && bit_idx_q == IDX_LAST) state_d = STOP;
      STOP:    if (decide) state_d = bit_val ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_run = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    decide   = tick_run && (tick_q == TICK_DEC);
    bit_val  = majority3(samp_a, samp_b, rx_s);
    shift_en = decide && (state_q == DATA);
    complete = decide && (state_q == STOP);
  end

  // Tick keeps running across bit boundaries so every bit is timed from the start edge.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      bit_idx_q <= '0;
    end else begin
      if (tick_run && state_d != IDLE && state_d != BREAK)
        tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      else
        tick_q <= '0;

      if (state_q == START)
        bit_idx_q <= '0;
      else if (shift_en && bit_idx_q != IDX_LAST)
        bit_idx_q <= bit_idx_q + 1'b1;
    end
  end

  // stage: sample capture and deserialiser (data path, no reset)
  always_ff @(posedge baud_clk) begin
    if (tick_q == TICK_A) samp_a <= rx_s;
    if (tick_q == TICK_B) samp_b <= rx_s;
    if (shift_en) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
  end

  // stage: output holding register and handshake
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      rx_if.rx_data_out      <= '0;
      rx_if.receive_done_out <= 1'b0;
      rx_if.frame_error_out  <= 1'b0;
      rx_if.overrun_out      <= 1'b0;
    end else if (complete) begin
      // An ack landing with the new byte frees the register, so the byte is taken, not dropped.
      if (!rx_if.receive_done_out || rx_if.rx_ack) begin
        rx_if.rx_data_out      <= shift_q;
        rx_if.receive_done_out <= 1'b1;
        rx_if.frame_error_out  <= ~bit_val;
        rx_if.overrun_out      <= 1'b0;
      end else begin
        rx_if.overrun_out      <= 1'b1;
      end
    end else if (rx_if.rx_ack && rx_if.receive_done_out) begin
      rx_if.receive_done_out <= 1'b0;
      rx_if.frame_error_out  <= 1'b0;
      rx_if.overrun_out      <= 1'b0;
    end
  end

endmodule
